// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS load/writeback slice.
// MIPS_LWLR_EN enables the unaligned LWL/LWR merge loads.
package mips_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } lw_state_t;

  localparam logic [4:0] MIPS_REG_ZERO = 5'd0;

  // Op is taken as raw bits so the unencoded value 7 can be rejected.
  function automatic logic load_is_legal(input logic [2:0] op, input logic [1:0] offset);
    case (op)
      LB, LBU: return 1'b1;
      LH, LHU: return ~offset[0];
      LW:      return (offset == 2'b00);
`ifdef MIPS_LWLR_EN
      LWL, LWR: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Request, Avalon-MM read and register-file write signals of the load stage.
// The master modport is the load stage itself; slave is its environment.
interface load_writeback_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;      // load_op_t encoding, raw so op 7 is expressible
  logic [31:0] req_addr;
  logic [4:0]  req_rt;
  logic [31:0] req_rt_old;

  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  logic        wb_write_control;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  logic        busy;
  logic        err;

  modport master (
    input  req_valid, req_op, req_addr, req_rt, req_rt_old,
    input  avm_waitrequest, avm_readdata,
    output req_ready, avm_address, avm_read, avm_byteenable,
    output wb_write_control, wb_write_reg, wb_write_data, busy, err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_rt, req_rt_old,
    output avm_waitrequest, avm_readdata,
    input  req_ready, avm_address, avm_read, avm_byteenable,
    input  wb_write_control, wb_write_reg, wb_write_data, busy, err
  );

endinterface

// File: rtl/load_align.sv
// Combinational lane selection, sign/zero extension and byte enables for loads.
// MIPS_LWLR_EN adds the LWL/LWR merge with the old rt value.
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] result,
  output logic [3:0]  byteenable
);

  logic [31:0] shifted;
  assign shifted = rdata >> {offset, 3'b000};

`ifndef MIPS_LWLR_EN
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byteenable = 4'b1111;
    case (op)
      LB, LBU: byteenable = 4'b0001 << offset;
      LH, LHU: byteenable = offset[1] ? 4'b1100 : 4'b0011;
      default: byteenable = 4'b1111;
    endcase
  end

  always_comb begin
    result = rdata;
    case (op)
      LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      LBU: result = {24'h0, shifted[7:0]};
      LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      LHU: result = {16'h0, shifted[15:0]};
`ifdef MIPS_LWLR_EN
      // LWL fills from the top; the low (3-k) bytes of rt survive.
      LWL: result = (rdata << {~offset, 3'b000})
                  | (rt_old & ~(32'hFFFF_FFFF << {~offset, 3'b000}));
      LWR: result = shifted | (rt_old & ~(32'hFFFF_FFFF >> {offset, 3'b000}));
`endif
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load-completion stage: accept a load, read it over Avalon-MM, write it back.
// MIPS_LWLR_EN enables LWL/LWR; otherwise they take the error path.
module load_writeback
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  load_writeback_if.master bus
);

  lw_state_t   state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  rt_q, rt_d;
  logic        avm_read_q, avm_read_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic [3:0]  avm_byteenable_q, avm_byteenable_d;
  logic        wb_write_control_q, wb_write_control_d;
  logic [4:0]  wb_write_reg_q, wb_write_reg_d;
  logic [31:0] wb_write_data_q, wb_write_data_d;
  logic        err_q, err_d;

  logic [31:0] align_rt_old;
`ifdef MIPS_LWLR_EN
  logic [31:0] rt_old_q, rt_old_d;
  assign align_rt_old = rt_old_q;
`else
  logic unused_rt_old;
  assign unused_rt_old = ^bus.req_rt_old;
  assign align_rt_old  = 32'h0;
`endif

  logic        is_idle;
  logic [2:0]  align_op;
  logic [1:0]  align_offset;
  logic [31:0] align_result;
  logic [3:0]  align_be;

  // In IDLE the aligner sees the incoming request (for byteenable);
  // afterwards it sees the captured request (for the result).
  assign is_idle      = (state_q == S_IDLE);
  assign align_op     = is_idle ? bus.req_op : op_q;
  assign align_offset = is_idle ? bus.req_addr[1:0] : offset_q;

  load_align u_align (
    .op         (align_op),
    .offset     (align_offset),
    .rdata      (bus.avm_readdata),
    .rt_old     (align_rt_old),
    .result     (align_result),
    .byteenable (align_be)
  );

  // NOTE: combinational logic uses blocking (=); only the always_ff below uses non-blocking (<=).
  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    offset_d           = offset_q;
    rt_d               = rt_q;
`ifdef MIPS_LWLR_EN
    rt_old_d           = rt_old_q;
`endif
    avm_read_d         = avm_read_q;
    avm_address_d      = avm_address_q;
    avm_byteenable_d   = avm_byteenable_q;
    wb_write_control_d = 1'b0;
    wb_write_reg_d     = wb_write_reg_q;
    wb_write_data_d    = wb_write_data_q;
    err_d              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          offset_d = bus.req_addr[1:0];
          rt_d     = bus.req_rt;
`ifdef MIPS_LWLR_EN
          rt_old_d = bus.req_rt_old;
`endif
          if (load_is_legal(bus.req_op, bus.req_addr[1:0])) begin
            state_d          = S_READ;
            avm_read_d       = 1'b1;
            avm_address_d    = {bus.req_addr[31:2], 2'b00};
            avm_byteenable_d = align_be;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (!bus.avm_waitrequest) begin
          state_d            = S_WRITE;
          avm_read_d         = 1'b0;
          wb_write_control_d = (rt_q != MIPS_REG_ZERO);
          wb_write_reg_d     = rt_q;
          wb_write_data_d    = align_result;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so outputs are defined from the first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      op_q               <= 3'd0;
      offset_q           <= 2'd0;
      rt_q               <= 5'd0;
`ifdef MIPS_LWLR_EN
      rt_old_q           <= 32'h0;
`endif
      avm_read_q         <= 1'b0;
      avm_address_q      <= 32'h0;
      avm_byteenable_q   <= 4'h0;
      wb_write_control_q <= 1'b0;
      wb_write_reg_q     <= 5'd0;
      wb_write_data_q    <= 32'h0;
      err_q              <= 1'b0;
    end else begin
      state_q            <= state_d;
      op_q               <= op_d;
      offset_q           <= offset_d;
      rt_q               <= rt_d;
`ifdef MIPS_LWLR_EN
      rt_old_q           <= rt_old_d;
`endif
      avm_read_q         <= avm_read_d;
      avm_address_q      <= avm_address_d;
      avm_byteenable_q   <= avm_byteenable_d;
      wb_write_control_q <= wb_write_control_d;
      wb_write_reg_q     <= wb_write_reg_d;
      wb_write_data_q    <= wb_write_data_d;
      err_q              <= err_d;
    end
  end

  assign bus.req_ready        = is_idle;
  assign bus.busy             = !is_idle;
  assign bus.avm_read         = avm_read_q;
  assign bus.avm_address      = avm_address_q;
  assign bus.avm_byteenable   = avm_byteenable_q;
  assign bus.wb_write_control = wb_write_control_q;
  assign bus.wb_write_reg     = wb_write_reg_q;
  assign bus.wb_write_data    = wb_write_data_q;
  assign bus.err              = err_q;

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed vector table, corner
// sequences (back-to-back, reset mid-read/write) and random loads vs a model.
module tb_load_writeback;
  import mips_pkg::*;

`ifdef MIPS_LWLR_EN
  localparam bit LWLR = 1'b1;
`else
  localparam bit LWLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_writeback_if lw ();

  load_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lw)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int          err_cycles;
    int          read_cycles;
    int          read_first;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        stable;
    int          wr_pulses;
    int          wr_idx;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        ready1;
    int          ready_in_read;
  } obs_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  rt;
    logic [31:0] rt_old;
    logic [31:0] rdata;
    int          waits;
    bit          exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
  } vec_t;

  // Reference model: derives the outcome from byte arithmetic, not bit slicing.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] rt_old, input logic [31:0] rdata,
                                output bit legal, output logic [3:0] be,
                                output logic [31:0] res);
    int k;
    longint d, r, b, h, p, q;
    k = int'(addr[1:0]);
    d = longint'(rdata);
    r = longint'(rt_old);
    b = (d >> (8 * k)) % 256;
    h = (d >> (8 * k)) % 65536;
    legal = 1'b0;
    be    = 4'b1111;
    res   = rdata;
    case (op)
      3'd0: begin legal = 1'b1; be = 4'(2 ** k); res = 32'(b >= 128 ? b - 256 : b); end
      3'd1: begin legal = 1'b1; be = 4'(2 ** k); res = 32'(b); end
      3'd2: begin legal = (k % 2 == 0); be = 4'(3 * 2 ** k); res = 32'(h >= 32768 ? h - 65536 : h); end
      3'd3: begin legal = (k % 2 == 0); be = 4'(3 * 2 ** k); res = 32'(h); end
      3'd4: begin legal = (k == 0); res = rdata; end
      3'd5: begin
        legal = LWLR;
        p     = 64'sd1 << (8 * (3 - k));
        res   = 32'(((d * p) % (64'sd1 << 32)) + (r % p));
      end
      3'd6: begin
        legal = LWLR;
        q     = 64'sd1 << (32 - 8 * k);
        res   = 32'((d >> (8 * k)) + (r - r % q));
      end
      default: legal = 1'b0;
    endcase
  endfunction

  // Issue one request and observe a fixed window of cycles after acceptance.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rt,
                          input logic [31:0] rt_old, input logic [31:0] rdata,
                          input int waits, input bit intrude, output obs_t o);
    o = '{default: 0};
    lw.req_valid       = 1'b1;
    lw.req_op          = op;
    lw.req_addr        = addr;
    lw.req_rt          = rt;
    lw.req_rt_old      = rt_old;
    lw.avm_waitrequest = 1'b1;
    lw.avm_readdata    = ~rdata;
    @(posedge clk); #1;
    lw.req_valid = 1'b0;
    for (int c = 1; c <= waits + 5; c++) begin
      if (c == 1) o.ready1 = lw.req_ready;
      if (lw.err) o.err_cycles++;
      if (lw.avm_read) begin
        o.read_cycles++;
        if (o.read_cycles == 1) begin
          o.read_first = c;
          o.addr       = lw.avm_address;
          o.be         = lw.avm_byteenable;
          o.stable     = 1'b1;
        end else if (lw.avm_address !== o.addr || lw.avm_byteenable !== o.be) begin
          o.stable = 1'b0;
        end
        o.ready_in_read += int'(lw.req_ready);
        lw.avm_waitrequest = (o.read_cycles <= waits);
        lw.avm_readdata    = lw.avm_waitrequest ? ~rdata : rdata;
        if (intrude) begin
          lw.req_valid = 1'b1;
          lw.req_op    = LB;
          lw.req_addr  = addr + 32'h100;
          lw.req_rt    = rt ^ 5'd1;
        end
      end else begin
        lw.req_valid       = 1'b0;
        lw.avm_waitrequest = 1'b1;
        lw.avm_readdata    = ~rdata;
      end
      if (lw.wb_write_control) begin
        o.wr_pulses++;
        o.wr_idx  = c;
        o.wr_reg  = lw.wb_write_reg;
        o.wr_data = lw.wb_write_data;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_load(input string tag, input vec_t v, input obs_t o);
    bit writes;
    writes = !v.exp_err && (v.rt != 5'd0);
    check({tag, " err"},    o.err_cycles,  v.exp_err ? 1 : 0);
    check({tag, " ready1"}, o.ready1,      v.exp_err ? 1 : 0);
    check({tag, " reads"},  o.read_cycles, v.exp_err ? 0 : v.waits + 1);
    check({tag, " writes"}, o.wr_pulses,   writes ? 1 : 0);
    if (!v.exp_err) begin
      check({tag, " rd_lat"}, o.read_first, 1);
      check({tag, " addr"},   o.addr,       {v.addr[31:2], 2'b00});
      check({tag, " be"},     o.be,         v.exp_be);
      check({tag, " stable"}, o.stable,     1);
    end
    if (writes) begin
      check({tag, " wr_lat"},  o.wr_idx,  v.waits + 2);
      check({tag, " wr_reg"},  o.wr_reg,  v.rt);
      check({tag, " wr_data"}, o.wr_data, v.exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    obs_t o;
    int   wr_count, wr_first, wr_last, cnt_rd, cnt_wr;

    lw.req_valid       = 1'b0;
    lw.req_op          = 3'd0;
    lw.req_addr        = 32'h0;
    lw.req_rt          = 5'd0;
    lw.req_rt_old      = 32'h0;
    lw.avm_waitrequest = 1'b0;
    lw.avm_readdata    = 32'h0;
    reset              = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst avm_read",    lw.avm_read,         0);
    check("rst wb_ctrl",     lw.wb_write_control, 0);
    check("rst err",         lw.err,              0);
    check("rst avm_address", lw.avm_address,      0);
    check("rst be",          lw.avm_byteenable,   0);
    check("rst wb_reg",      lw.wb_write_reg,     0);
    check("rst wb_data",     lw.wb_write_data,    0);
    check("rst req_ready",   lw.req_ready,        1);
    check("rst busy",        lw.busy,             0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{LW,   32'h0000_1000, 5'd12, 32'h0,         32'hDEADBEEF, 3, 1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{LB,   32'h0000_1003, 5'd5,  32'h0,         32'h80FF1234, 0, 1'b0, 4'b1000, 32'hFFFFFF80};
    vecs[2]  = '{LBU,  32'h0000_1003, 5'd6,  32'h0,         32'h80FF1234, 1, 1'b0, 4'b1000, 32'h00000080};
    vecs[3]  = '{LH,   32'h0000_1001, 5'd7,  32'h0,         32'h80FF1234, 0, 1'b1, 4'b0000, 32'h0};
    vecs[4]  = '{LHU,  32'h0000_1002, 5'd8,  32'h0,         32'h8001ABCD, 0, 1'b0, 4'b1100, 32'h00008001};
    vecs[5]  = '{LW,   32'h0000_2000, 5'd0,  32'h0,         32'hCAFEF00D, 1, 1'b0, 4'b1111, 32'hCAFEF00D};
`ifdef MIPS_LWLR_EN
    vecs[6]  = '{LWL,  32'h0000_2001, 5'd9,  32'h11223344,  32'hAABBCCDD, 0, 1'b0, 4'b1111, 32'hCCDD3344};
    vecs[7]  = '{LWR,  32'h0000_2001, 5'd10, 32'h11223344,  32'hAABBCCDD, 0, 1'b0, 4'b1111, 32'h11AABBCC};
`else
    vecs[6]  = '{LWL,  32'h0000_2001, 5'd9,  32'h11223344,  32'hAABBCCDD, 0, 1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{LWR,  32'h0000_2001, 5'd10, 32'h11223344,  32'hAABBCCDD, 0, 1'b1, 4'b0000, 32'h0};
`endif
    vecs[8]  = '{3'd7, 32'h0000_3000, 5'd11, 32'h0,         32'h12345678, 0, 1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{LW,   32'h0000_3002, 5'd11, 32'h0,         32'h12345678, 0, 1'b1, 4'b0000, 32'h0};
    vecs[10] = '{LH,   32'h0000_1002, 5'd11, 32'h0,         32'h8001ABCD, 2, 1'b0, 4'b1100, 32'hFFFF8001};
    vecs[11] = '{LB,   32'h0000_1000, 5'd12, 32'h0,         32'h80FF1234, 0, 1'b0, 4'b0001, 32'h00000034};

    for (int i = 0; i < 12; i++) begin
      run_load(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rt_old, vecs[i].rdata,
               vecs[i].waits, (i == 5), o);
      check_load($sformatf("vec%0d", i), vecs[i], o);
      if (i == 5) check("vec5 ready_in_read", o.ready_in_read, 0);
    end

    // Back-to-back: a held request is re-accepted every third cycle.
    lw.req_valid       = 1'b1;
    lw.req_op          = LW;
    lw.req_addr        = 32'h0000_3000;
    lw.req_rt          = 5'd3;
    lw.avm_waitrequest = 1'b0;
    lw.avm_readdata    = 32'h01020304;
    wr_count = 0; wr_first = 0; wr_last = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 12; c++) begin
      if (lw.wb_write_control) begin
        wr_count++;
        if (wr_count == 1) wr_first = c;
        wr_last = c;
      end
      if (c == 12) lw.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b count", wr_count, 4);
    check("b2b first", wr_first, 2);
    check("b2b last",  wr_last,  11);
    repeat (3) @(posedge clk);
    #1;

    // Reset while READ is stalled.
    lw.req_valid       = 1'b1;
    lw.req_op          = LW;
    lw.req_addr        = 32'h0000_4000;
    lw.req_rt          = 5'd7;
    lw.avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    lw.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rrd pre avm_read", lw.avm_read, 1);
    #2 reset = 1'b0;
    #1;
    check("rrd avm_read", lw.avm_read,  0);
    check("rrd busy",     lw.busy,      0);
    check("rrd ready",    lw.req_ready, 1);
    lw.avm_waitrequest = 1'b0;
    lw.avm_readdata    = 32'h55AA55AA;
    @(negedge clk) reset = 1'b1;
    cnt_rd = 0; cnt_wr = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cnt_rd += int'(lw.avm_read);
      cnt_wr += int'(lw.wb_write_control);
    end
    check("rrd no read",  cnt_rd, 0);
    check("rrd no write", cnt_wr, 0);

    // Reset while WRITE is pending.
    lw.req_valid = 1'b1;
    lw.req_op    = LW;
    lw.req_addr  = 32'h0000_5000;
    lw.req_rt    = 5'd9;
    @(posedge clk); #1;
    lw.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rwr pre wb_ctrl", lw.wb_write_control, 1);
    #2 reset = 1'b0;
    #1;
    check("rwr wb_ctrl", lw.wb_write_control, 0);
    check("rwr busy",    lw.busy,             0);
    @(negedge clk) reset = 1'b1;
    cnt_wr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      cnt_wr += int'(lw.wb_write_control);
    end
    check("rwr no write", cnt_wr, 0);

    // Random loads against the reference model.
    for (int n = 0; n < 150; n++) begin
      vec_t v;
      bit   legal;
      v.op     = 3'($urandom_range(0, 7));
      v.addr   = $urandom;
      v.rt     = 5'($urandom_range(0, 31));
      v.rt_old = $urandom;
      v.rdata  = $urandom;
      v.waits  = $urandom_range(0, 2);
      model(v.op, v.addr, v.rt_old, v.rdata, legal, v.exp_be, v.exp_data);
      v.exp_err = !legal;
      run_load(v.op, v.addr, v.rt, v.rt_old, v.rdata, v.waits, 1'b0, o);
      check_load($sformatf("rnd%0d op%0d a%08h", n, v.op, v.addr), v, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_writeback.md
# load_writeback

Load-completion stage between execute and the register file write port. Accepts one load request at a time, performs the read on the Avalon-MM data bus, and waits through any number of `waitrequest` cycles. It then extracts, sign/zero-extends or merges the returned bytes and drives a single-cycle write into the register file (`write_control` / `write_reg` / `write_data`). It also checks alignment and flags misaligned loads without touching the bus.

## Interface
Parameters: none. All widths are fixed by the MIPS-I ISA: 32-bit data, 5-bit register index.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  reset, asynchronous, active-low; clears all state when 0
- `req_valid`  in  1  load request present
- `req_ready`  out  1  stage can accept a request
- `req_op`  in  3  load type, `load_op_t`
- `req_addr`  in  32  effective byte address
- `req_rt`  in  5  destination register
- `req_rt_old`  in  32  current `rt` value, used for the LWL/LWR merge
- `avm_address`  out  32  word-aligned bus address
- `avm_read`  out  1  bus read strobe
- `avm_byteenable`  out  4  active byte lanes
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  returned word
- `wb_write_control`  out  1  register-file write enable
- `wb_write_reg`  out  5  register-file write index
- `wb_write_data`  out  32  register-file write data
- `busy`  out  1  request in flight (`state != IDLE`)
- `err`  out  1  one-cycle pulse: misaligned address or unsupported op

## Operation
- FSM states: IDLE, READ, WRITE. All outputs are registered except `req_ready` and `busy`, which decode the state.
- **IDLE**
  - `req_ready = 1`.
  - On `req_valid`, capture `op`, `addr`, `rt`, `rt_old`.
  - If the request is illegal, pulse `err` next cycle and stay in IDLE. Illegal means any of:
    - LH/LHU with `addr[0] = 1`
    - LW with `addr[1:0] != 0`
    - `op = 7`
  - Otherwise go to READ.
- **READ**
  - Drive `avm_read = 1`, `avm_address = {addr[31:2], 2'b00}`, and `avm_byteenable` as follows:
    - LB/LBU: `4'b0001 << addr[1:0]`
    - LH/LHU: `addr[1] ? 4'b1100 : 4'b0011`
    - LW/LWL/LWR: `4'b1111`
  - Hold address, read strobe and byteenable stable while `avm_waitrequest = 1`.
  - On the first cycle with `avm_waitrequest = 0`, latch the aligned result and go to WRITE.
- **WRITE**
  - `wb_write_control = 1` for exactly one cycle, with `wb_write_reg = rt` and `wb_write_data` = the aligned result.
  - Return to IDLE.
  - If `rt = 0`, the bus read still happens but `wb_write_control` stays 0.
- Byte order is little-endian: byte at offset k is `avm_readdata[8k+7:8k]`.
- Alignment rules, with k = `addr[1:0]`:
  - LB: sign-extend byte k.
  - LBU: zero-extend byte k.
  - LH: sign-extend the halfword at lanes `{k+1, k}`.
  - LHU: zero-extend the halfword at lanes `{k+1, k}`.
  - LW: the word unchanged.
  - LWL: `(rdata << 8*(3-k)) | (rt_old & ((1 << 8*(3-k)) - 1))`.
  - LWR: `(rdata >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k))`.
- Requests arriving while not in IDLE are ignored; `req_ready = 0`.

## Timing
- **Reset values**: state = IDLE; `avm_read`, `wb_write_control`, `err` = 0; `avm_address`, `avm_byteenable`, `wb_write_reg`, `wb_write_data` = 0. `req_ready = 1` and `busy = 0` follow from state = IDLE.
- **Best-case latency**: request accepted at edge N, `avm_read` high in cycle N+1, write pulse in cycle N+2. Each `waitrequest` cycle adds one cycle.
- **Back-to-back**: the next request can be accepted in the cycle after WRITE. Throughput is one load per 3 cycles.
- **Error path**: `err` is high for exactly the one cycle after acceptance. No bus access and no write. `req_ready` remains 1.
- **Reset mid-operation**: asserting `reset` (driving it low) in READ drops `avm_read` immediately (asynchronously) and discards the load. Asserting it in WRITE suppresses the pending write.

## Configuration
- `MIPS_LWLR_EN` defined: LWL (op 5) and LWR (op 6) are supported as described above.
- `MIPS_LWLR_EN` undefined: op 5 and op 6 are illegal and take the `err` path. `req_rt_old` remains a port but is unused. Merge logic is not synthesised.

## Structure
- `mips_pkg` holds:
  - `load_op_t` enum: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6
  - the FSM state typedef
  - the constant `MIPS_REG_ZERO = 5'd0`
- Sub-module `load_align` is purely combinational and computes `(op, offset, rdata, rt_old) -> result` and `byteenable`. The FSM lives in `load_writeback`.

## Test plan
- **LW with waits**: LW, addr `0x1000`, rt 12, `readdata = 0xDEADBEEF`, 3 `waitrequest` cycles -> `avm_address = 0x1000`, byteenable `4'b1111` held 4 cycles; then one write pulse, reg 12 = `0xDEADBEEF`.
- **LB/LBU lanes**: LB, addr `0x1003`, `readdata = 0x80FF1234` -> byteenable `4'b1000`, write `0xFFFFFF80`. LBU at the same address -> write `0x00000080`.
- **Misaligned halfword**: LH, addr `0x1001` -> `err` pulse for 1 cycle, `avm_read` never asserted, no write. LHU, addr `0x1002`, `readdata = 0x8001xxxx` -> write `0x00008001`.
- **Destination zero**: LW to rt 0 -> bus read occurs, `wb_write_control` stays 0. A request presented during READ is ignored (`req_ready = 0`).
- **LWL/LWR** (with `MIPS_LWLR_EN`), `rt_old = 0x11223344`, `rdata = 0xAABBCCDD`:
  - LWL, k=1 -> `0xCCDD3344`
  - LWR, k=1 -> `0x11AABBCC`
  - without the macro -> `err` pulse.
- **Reset mid-read**: assert `reset` low while READ is stalled by `waitrequest` -> `avm_read` = 0 asynchronously, state IDLE, no write after release.
